// File: rtl/updown_sweep_controller_if.sv
// updown_sweep_controller_if: configuration handshake bundle for the sweep controller
// Signals: cfg_valid/cfg_ready handshake; cfg_low/cfg_high limits, cfg_step step size,
//          cfg_dwell endpoint hold cycles, cfg_cont continuous(1)/one-shot(0) select.
// Modports: master drives the configuration, slave (the controller) returns cfg_ready.
interface updown_sweep_controller_if #(
    parameter int WIDTH       = 8,
    parameter int DWELL_WIDTH = 4
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [WIDTH-1:0]       cfg_low;
    logic [WIDTH-1:0]       cfg_high;
    logic [WIDTH-1:0]       cfg_step;
    logic [DWELL_WIDTH-1:0] cfg_dwell;
    logic                   cfg_cont;
    modport master (output cfg_valid, cfg_low, cfg_high, cfg_step, cfg_dwell, cfg_cont, input cfg_ready);
    modport slave (input cfg_valid, cfg_low, cfg_high, cfg_step, cfg_dwell, cfg_cont, output cfg_ready);
endinterface

// File: rtl/updown_sweep_controller.sv
// updown_sweep_controller: triangle sweep sequencer between programmable low/high limits
// Ports: clk; rst (asynchronous, active-high); cfg (slave side of updown_sweep_controller_if);
//        start/stop sweep control; count (sweep value), dir (1 = up), busy (not idle);
//        turn (endpoint reached), done (one-shot finished), cfg_err (config rejected) pulses.
// Option: define UPDOWN_SWEEP_STATUS_EN to add sweep_cnt[15:0], a saturating count of
//         completed low->high->low periods, cleared when a sweep starts.
module updown_sweep_controller #(
    parameter int WIDTH       = 8,
    parameter int DWELL_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    updown_sweep_controller_if.slave cfg,
    input  logic                     start,
    input  logic                     stop,
    output logic [WIDTH-1:0]         count,
    output logic                     dir,
    output logic                     busy,
    output logic                     turn,
    output logic                     done,
    output logic                     cfg_err
`ifdef UPDOWN_SWEEP_STATUS_EN
    ,
    output logic [15:0]              sweep_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, UP, DOWN, HOLD} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] low_r, high_r, step_r, low_n, high_n, step_n, count_n;
    logic [DWELL_WIDTH-1:0] dwell_r, dwell_n, hold_cnt, hold_n;
    logic cont_r, cont_n, ret_up, ret_n, dir_n, turn_n, done_n, err_n, accept, cfg_ok;
    logic [WIDTH:0] sum, diff;

    assign cfg.cfg_ready = state == IDLE;
    assign busy = state != IDLE;
    assign accept = cfg.cfg_valid && state == IDLE;
    assign cfg_ok = accept && cfg.cfg_low <= cfg.cfg_high;
    // Accepted values are forwarded combinationally so a coincident start already uses them.
    assign low_n = cfg_ok ? cfg.cfg_low : low_r;
    assign high_n = cfg_ok ? cfg.cfg_high : high_r;
    assign step_n = cfg_ok ? (cfg.cfg_step == '0 ? WIDTH'(1) : cfg.cfg_step) : step_r;
    assign dwell_n = cfg_ok ? cfg.cfg_dwell : dwell_r;
    assign cont_n = cfg_ok ? cfg.cfg_cont : cont_r;
    // The extra bit exposes overshoot past the top and borrow below zero, so nothing wraps.
    assign sum = {1'b0, count} + {1'b0, step_r};
    assign diff = {1'b0, count} - {1'b0, step_r};

    always_comb begin
        state_n = state;
        count_n = count;
        dir_n = dir;
        ret_n = ret_up;
        hold_n = hold_cnt;
        turn_n = 1'b0;
        done_n = 1'b0;
        err_n = accept && !cfg_ok;
        if (busy && stop) begin
            state_n = IDLE;
            dir_n = 1'b0;
        end else begin
            case (state)
                IDLE: if (start && !stop) begin
                    count_n = low_n;
                    dir_n = 1'b1;
                    state_n = UP;
                end
                UP: if (sum >= {1'b0, high_r}) begin
                    count_n = high_r;
                    turn_n = 1'b1;
                    if (dwell_r != '0) begin
                        state_n = HOLD;
                        hold_n = dwell_r;
                        ret_n = 1'b0;
                    end else begin
                        state_n = DOWN;
                        dir_n = 1'b0;
                    end
                end else begin
                    count_n = sum[WIDTH-1:0];
                end
                DOWN: if (diff[WIDTH] || diff[WIDTH-1:0] <= low_r) begin
                    count_n = low_r;
                    turn_n = 1'b1;
                    if (!cont_r) begin
                        done_n = 1'b1;
                        dir_n = 1'b0;
                        state_n = IDLE;
                    end else if (dwell_r != '0) begin
                        state_n = HOLD;
                        hold_n = dwell_r;
                        ret_n = 1'b1;
                    end else begin
                        state_n = UP;
                        dir_n = 1'b1;
                    end
                end else begin
                    count_n = diff[WIDTH-1:0];
                end
                HOLD: if (hold_cnt <= DWELL_WIDTH'(1)) begin
                    // dir only flips once the hold is over and travel resumes
                    state_n = ret_up ? UP : DOWN;
                    dir_n = ret_up;
                end else begin
                    hold_n = hold_cnt - DWELL_WIDTH'(1);
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            dir <= 1'b0;
            turn <= 1'b0;
            done <= 1'b0;
            cfg_err <= 1'b0;
            low_r <= '0;
            high_r <= '1;
            step_r <= WIDTH'(1);
            dwell_r <= '0;
            cont_r <= 1'b0;
            ret_up <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            dir <= dir_n;
            turn <= turn_n;
            done <= done_n;
            cfg_err <= err_n;
            low_r <= low_n;
            high_r <= high_n;
            step_r <= step_n;
            dwell_r <= dwell_n;
            cont_r <= cont_n;
            ret_up <= ret_n;
            hold_cnt <= hold_n;
        end
    end

`ifdef UPDOWN_SWEEP_STATUS_EN
    // A turn raised from DOWN is always the low endpoint, i.e. one completed period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sweep_cnt <= '0;
        else if (state == IDLE && start && !stop) sweep_cnt <= '0;
        else if (state == DOWN && turn_n && sweep_cnt != 16'hFFFF) sweep_cnt <= sweep_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_updown_sweep_controller.sv
// tb_updown_sweep_controller: vector table, directed corner sequences and randomized sweeps vs a trace model
module tb_updown_sweep_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic [7:0] count;
    logic dir, busy, turn, done, cfg_err;
`ifdef UPDOWN_SWEEP_STATUS_EN
    logic [15:0] sweep_cnt;
`endif
    int checks = 0;
    int errors = 0;

    updown_sweep_controller_if #(.WIDTH(8), .DWELL_WIDTH(4)) bus ();

    updown_sweep_controller #(.WIDTH(8), .DWELL_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .cfg(bus), .start(start), .stop(stop),
        .count(count), .dir(dir), .busy(busy), .turn(turn), .done(done), .cfg_err(cfg_err)
`ifdef UPDOWN_SWEEP_STATUS_EN
        , .sweep_cnt(sweep_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    typedef struct packed {
        logic [7:0] c;
        logic       d;
        logic       b;
        logic       t;
        logic       dn;
    } obs_t;

    typedef struct {
        int lo; int hi; int st; int dw; int n;
        int e[8];
        logic [7:0] tm;
    } vec_t;

    obs_t q[$];
    int sc_q[$];

    function automatic obs_t mk(int c, bit d, bit b, bit t, bit dn);
        return {8'(c), d, b, t, dn};
    endfunction

    function automatic obs_t cur();
        return {count, dir, busy, turn, done};
    endfunction

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    function automatic void push(int c, bit d, bit b, bit t, bit dn, int sc);
        q.push_back(mk(c, d, b, t, dn));
        sc_q.push_back(sc);
    endfunction

    // Trace of what the outputs should show each cycle after the start edge.
    // An endpoint is displayed dw+1 times; the last of those already shows the new direction.
    function automatic void build(int lo, int hi, int st, int dw, bit cont, int periods);
        int v = lo;
        int sc = 0;
        int s = (st == 0) ? 1 : st;
        q.delete();
        sc_q.delete();
        push(v, 1, 1, 0, 0, sc);
        for (int p = 0; p < periods; p++) begin
            while (v + s < hi) begin
                v += s;
                push(v, 1, 1, 0, 0, sc);
            end
            v = hi;
            for (int i = 0; i <= dw; i++) push(hi, i < dw, 1, i == 0, 0, sc);
            while (v - s > lo) begin
                v -= s;
                push(v, 0, 1, 0, 0, sc);
            end
            v = lo;
            sc++;
            if (!cont) begin
                push(lo, 0, 0, 1, 1, sc);
                return;
            end
            for (int i = 0; i <= dw; i++) push(lo, i >= dw, 1, i == 0, 0, sc);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(int lo, int hi, int st, int dw, bit cont);
        bus.cfg_valid = 1'b1;
        bus.cfg_low = 8'(lo);
        bus.cfg_high = 8'(hi);
        bus.cfg_step = 8'(st);
        bus.cfg_dwell = 4'(dw);
        bus.cfg_cont = cont;
    endtask

    task automatic run_model(int lo, int hi, int st, int dw, bit cont, int periods, bit do_stop);
        int stop_at;
        build(lo, hi, st, dw, cont, periods);
        stop_at = do_stop ? int'($urandom_range(0, q.size() - 2)) : -1;
        set_cfg(lo, hi, st, dw, cont);
        start = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
        start = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            if (i > 0) tick();
            check($sformatf("trace[%0d] lo=%0d hi=%0d st=%0d dw=%0d c=%0b", i, lo, hi, st, dw, cont),
                  32'(cur()), 32'(q[i]));
`ifdef UPDOWN_SWEEP_STATUS_EN
            check($sformatf("sweep_cnt[%0d]", i), 32'(sweep_cnt), 32'(sc_q[i]));
`endif
            if (i == stop_at) begin
                stop = 1'b1;
                tick();
                stop = 1'b0;
                check("stop_mid", 32'(cur()), 32'(mk(int'(q[i].c), 0, 0, 0, 0)));
                return;
            end
        end
        if (cont) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
            check("stop_cont", 32'(cur()), 32'(mk(int'(q[q.size() - 1].c), 0, 0, 0, 0)));
        end else begin
            tick();
            check("idle_after_done", 32'(cur()), 32'(mk(lo, 0, 0, 0, 0)));
        end
    endtask

    initial begin
        vec_t tab[6];
        tab[0] = '{2, 8, 3, 0, 5, '{2, 5, 8, 5, 2, 0, 0, 0}, 8'h14};
        tab[1] = '{0, 255, 200, 0, 5, '{0, 200, 255, 55, 0, 0, 0, 0}, 8'h14};
        tab[2] = '{4, 4, 7, 0, 3, '{4, 4, 4, 0, 0, 0, 0, 0}, 8'h06};
        tab[3] = '{3, 6, 0, 0, 7, '{3, 4, 5, 6, 5, 4, 3, 0}, 8'h48};
        tab[4] = '{10, 20, 15, 0, 3, '{10, 20, 10, 0, 0, 0, 0, 0}, 8'h06};
        tab[5] = '{1, 3, 1, 2, 7, '{1, 2, 3, 3, 3, 2, 1, 0}, 8'h44};
        bus.cfg_valid = 1'b0;
        bus.cfg_low = '0;
        bus.cfg_high = '0;
        bus.cfg_step = '0;
        bus.cfg_dwell = '0;
        bus.cfg_cont = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_outputs", 32'({cur(), cfg_err, bus.cfg_ready}), 32'({mk(0, 0, 0, 0, 0), 1'b0, 1'b1}));
`ifdef UPDOWN_SWEEP_STATUS_EN
        check("reset_sweep_cnt", 32'(sweep_cnt), 32'd0);
`endif
        for (int r = 0; r < 6; r++) begin
            set_cfg(tab[r].lo, tab[r].hi, tab[r].st, tab[r].dw, 1'b0);
            start = 1'b1;
            tick();
            bus.cfg_valid = 1'b0;
            start = 1'b0;
            for (int i = 0; i < tab[r].n; i++) begin
                if (i > 0) tick();
                check($sformatf("vec%0d[%0d] {count,turn,done,busy}", r, i),
                      32'({count, turn, done, busy}),
                      32'({8'(tab[r].e[i]), tab[r].tm[i], i == tab[r].n - 1, i != tab[r].n - 1}));
            end
        end
        // rejected config keeps the last accepted one (low=1)
        set_cfg(9, 4, 1, 0, 0);
        tick();
        bus.cfg_valid = 1'b0;
        check("cfg_err_pulse", 32'(cfg_err), 32'd1);
        tick();
        check("cfg_err_clear", 32'(cfg_err), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("cfg_retained", 32'({count, busy}), 32'({8'd1, 1'b1}));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        // config presented while busy is ignored
        set_cfg(2, 8, 3, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        set_cfg(50, 60, 1, 0, 0);
        check("cfg_ready_busy", 32'(bus.cfg_ready), 32'd0);
        repeat (4) tick();
        bus.cfg_valid = 1'b0;
        check("busy_cfg_done", 32'({count, done, busy}), 32'({8'd2, 1'b1, 1'b0}));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_cfg_ignored", 32'(count), 32'd2);
        tick();
        check("old_step_used", 32'(count), 32'd5);
        // stop at count=5, which also beats the endpoint that would land next
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_at_5", 32'(cur()), 32'(mk(5, 0, 0, 0, 0)));
        tick();
        check("stop_stays_idle", 32'(cur()), 32'(mk(5, 0, 0, 0, 0)));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_reloads_low", 32'({count, busy, dir}), 32'({8'd2, 1'b1, 1'b1}));
        stop = 1'b1;
        tick();
        // start together with stop in IDLE is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        check("start_with_stop", 32'(busy), 32'd0);
        // asynchronous reset in the middle of a hold
        set_cfg(1, 3, 1, 3, 1);
        start = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        check("hold_before_reset", 32'({count, busy, turn}), 32'({8'd3, 1'b1, 1'b0}));
        #2 rst = 1'b1;
        #1;
        check("async_reset", 32'({cur(), cfg_err}), 32'({mk(0, 0, 0, 0, 0), 1'b0}));
`ifdef UPDOWN_SWEEP_STATUS_EN
        check("async_reset_sweep_cnt", 32'(sweep_cnt), 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("reset_cfg_low", 32'(count), 32'd0);
        tick();
        check("reset_cfg_step", 32'(count), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        run_model(1, 3, 1, 3, 1'b1, 2, 1'b0);
        run_model(5, 5, 2, 1, 1'b1, 2, 1'b0);
        for (int n = 0; n < 40; n++) begin
            int lo, hi, st, dw;
            bit cont;
            lo = $urandom_range(0, 255);
            if ($urandom_range(0, 2) == 0) begin
                st = $urandom_range(0, 3);
                hi = $urandom_range(lo, (lo + 30 > 255) ? 255 : lo + 30);
            end else begin
                st = $urandom_range(4, 255);
                hi = $urandom_range(lo, 255);
            end
            dw = $urandom_range(0, 3);
            cont = 1'($urandom_range(0, 1));
            run_model(lo, hi, st, dw, cont, cont ? $urandom_range(1, 2) : 1, $urandom_range(0, 3) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
